// File: rtl/clkgen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// channel FSM states, default channel settings and the cfg_ch width helper.
package clkgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } ch_state_e;

    localparam int CLKGEN_NUM_CH    = 4;
    localparam int CLKGEN_CNT_W     = 4;
    localparam int CLKGEN_DEF_HIGH  = 3;
    localparam int CLKGEN_DEF_LOW   = 3;
    localparam int CLKGEN_DEF_PHASE = 0;

    // cfg_ch is never narrower than one bit, even for a single channel.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_generator_if.sv
// Control/config bus and divided-clock outputs of multi_clock_generator.
// state_dbg carries each channel's FSM state (2 bits per channel, channel 0 in the LSBs).
interface multi_clock_generator_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
);
    localparam int CH_W = clkgen_pkg::ch_idx_w(NUM_CH);

    // cfg_we is a single-cycle strobe with no back-pressure: a write is
    // always accepted on the rising edge where cfg_we is sampled high.
    logic [NUM_CH-1:0]   enable;
    logic                sync;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_high;
    logic [CNT_W-1:0]    cfg_low;
    logic [CNT_W-1:0]    cfg_phase;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   period_start;
    logic [NUM_CH-1:0]   cfg_pending;
    logic [2*NUM_CH-1:0] state_dbg;

    modport master (
        output enable, sync, cfg_we, cfg_ch, cfg_high, cfg_low, cfg_phase,
        input  clk_out, period_start, cfg_pending, state_dbg
    );

    modport slave (
        input  enable, sync, cfg_we, cfg_ch, cfg_high, cfg_low, cfg_phase,
        output clk_out, period_start, cfg_pending, state_dbg
    );

endinterface

// File: rtl/clkgen_channel.sv
// One divided-clock channel: phase/high/low FSM with a down-counter and an
// active/shadow config pair; shadow settings take effect only at safe points.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int DEF_HIGH  = 3,
    parameter int DEF_LOW   = 3,
    parameter int DEF_PHASE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_high,
    input  logic [CNT_W-1:0] wr_low,
    input  logic [CNT_W-1:0] wr_phase,
    output logic             clk_out,
    output logic             period_start,
    output logic             cfg_pending,
    output ch_state_e        state_dbg
);

    typedef struct packed {
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] low;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{phase: CNT_W'(DEF_PHASE),
                                 low:   CNT_W'(DEF_LOW),
                                 high:  CNT_W'(DEF_HIGH)};
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             active_q, shadow_q, eff_cfg, nxt_cfg;
    logic             pending_q, boot_q, boot_d, clk_q, start_q;
    logic             apply, begin_period, start;

    // Config that becomes active if the shadow is applied this edge.
    assign eff_cfg = pending_q ? shadow_q : active_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        apply        = 1'b0;
        begin_period = 1'b0;
        start        = 1'b0;
        nxt_cfg      = active_q;
        boot_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                apply = 1'b1;
                if (enable) begin
                    state_d = ST_PHASE;
                    cnt_d   = eff_cfg.phase;
                end
            end
            ST_PHASE: begin
                // A channel disabled since reset release still finishes its phase count.
                if (!enable && !boot_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    begin_period = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (active_q.low != '0) begin
                    state_d = ST_LOW;
                    cnt_d   = active_q.low - ONE;
                end else begin
                    apply = 1'b1;
                    if (enable) begin_period = 1'b1;
                    else        state_d      = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    apply = 1'b1;
                    if (enable) begin_period = 1'b1;
                    else        state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (apply) nxt_cfg = eff_cfg;

        // A zero high count skips HIGH entirely, so the output never rises.
        if (begin_period) begin
            if (nxt_cfg.high != '0) begin
                state_d = ST_HIGH;
                cnt_d   = nxt_cfg.high - ONE;
                start   = 1'b1;
            end else begin
                state_d = ST_LOW;
                cnt_d   = (nxt_cfg.low != '0) ? nxt_cfg.low - ONE : '0;
            end
        end

        if (sync && enable) begin
            apply   = 1'b1;
            nxt_cfg = eff_cfg;
            state_d = ST_PHASE;
            cnt_d   = eff_cfg.phase;
            start   = 1'b0;
        end

        boot_d = boot_q && !enable && (state_d == ST_PHASE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PHASE;
            cnt_q     <= DEF_CFG.phase;
            active_q  <= DEF_CFG;
            shadow_q  <= DEF_CFG;
            pending_q <= 1'b0;
            boot_q    <= 1'b1;
            clk_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= nxt_cfg;
            boot_q   <= boot_d;
            // A write coinciding with an apply lands in the shadow for the next apply.
            if (wr_en) begin
                shadow_q  <= '{phase: wr_phase, low: wr_low, high: wr_high};
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
            clk_q   <= (state_d == ST_HIGH);
            start_q <= start;
        end
    end

    assign clk_out      = clk_q;
    assign period_start = start_q;
    assign cfg_pending  = pending_q;
    assign state_dbg    = state_q;

endmodule

// File: rtl/multi_clock_generator.sv
// NUM_CH independently programmable divided clock enables from one master clock.
// The top only decodes config writes and fans out sync/enable to the channels.
module multi_clock_generator
    import clkgen_pkg::*;
#(
    parameter int NUM_CH    = CLKGEN_NUM_CH,
    parameter int CNT_W     = CLKGEN_CNT_W,
    parameter int DEF_HIGH  = CLKGEN_DEF_HIGH,
    parameter int DEF_LOW   = CLKGEN_DEF_LOW,
    parameter int DEF_PHASE = CLKGEN_DEF_PHASE
) (
    input logic                    clock,
    input logic                    reset,
    multi_clock_generator_if.slave bus
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic      wr_en;
        ch_state_e st;

        // Codes at or above NUM_CH match no channel, so such writes are dropped.
        assign wr_en = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        clkgen_channel #(
            .CNT_W     (CNT_W),
            .DEF_HIGH  (DEF_HIGH),
            .DEF_LOW   (DEF_LOW),
            .DEF_PHASE (DEF_PHASE)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .enable       (bus.enable[i]),
            .sync         (bus.sync),
            .wr_en        (wr_en),
            .wr_high      (bus.cfg_high),
            .wr_low       (bus.cfg_low),
            .wr_phase     (bus.cfg_phase),
            .clk_out      (bus.clk_out[i]),
            .period_start (bus.period_start[i]),
            .cfg_pending  (bus.cfg_pending[i]),
            .state_dbg    (st)
        );

        assign bus.state_dbg[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Bench for multi_clock_generator: waveform-level reference model feeding an
// expected queue, drained and compared by a negedge monitor.
module tb_multi_clock_generator;
    import clkgen_pkg::*;

    // Five channels leave cfg_ch codes 5..7 unused.
    localparam int NC  = 5;
    localparam int CW  = 4;
    localparam int CHW = 3;
    localparam int DH  = 3;
    localparam int DL  = 3;
    localparam int DP  = 0;
    localparam int W   = 3 * NC;

    typedef enum int {K_IDLE, K_PHASE, K_PERIOD} kind_e;

    logic clock = 1'b0;
    logic reset = 1'b0;

    multi_clock_generator_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

    multi_clock_generator #(
        .NUM_CH(NC), .CNT_W(CW), .DEF_HIGH(DH), .DEF_LOW(DL), .DEF_PHASE(DP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Each channel plays a segment (phase gap, one period, or idle) cycle by cycle.
    int    m_h[NC], m_l[NC], m_p[NC];
    int    s_h[NC], s_l[NC], s_p[NC];
    bit    m_pend[NC], m_boot[NC];
    kind_e m_kind[NC];
    int    m_pos[NC], m_len[NC], m_seg_h[NC];

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    function automatic void m_apply(int c);
        if (m_pend[c]) begin
            m_h[c] = s_h[c]; m_l[c] = s_l[c]; m_p[c] = s_p[c];
            m_pend[c] = 1'b0;
        end
    endfunction

    function automatic void m_seg_phase(int c);
        m_kind[c] = K_PHASE; m_len[c] = m_p[c] + 1; m_pos[c] = 0;
    endfunction

    function automatic void m_seg_period(int c);
        m_kind[c]  = K_PERIOD;
        m_seg_h[c] = m_h[c];
        m_pos[c]   = 0;
        if (m_h[c] != 0)      m_len[c] = m_h[c] + m_l[c];
        else if (m_l[c] != 0) m_len[c] = m_l[c];
        else                  m_len[c] = 1;
    endfunction

    function automatic void m_seg_idle(int c);
        m_kind[c] = K_IDLE; m_len[c] = 1; m_pos[c] = 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin
            m_h[i] = DH; m_l[i] = DL; m_p[i] = DP;
            s_h[i] = DH; s_l[i] = DL; s_p[i] = DP;
            m_pend[i] = 1'b0; m_boot[i] = 1'b1;
            m_seg_phase(i);
        end
    endfunction

    function automatic void m_edge(int c, bit en, bit sy, bit wr, int wh, int wl, int wp);
        if (sy && en) begin
            m_apply(c); m_seg_phase(c);
        end else if (m_kind[c] == K_PHASE && !en && !m_boot[c]) begin
            m_seg_idle(c);
        end else if (m_pos[c] + 1 < m_len[c]) begin
            m_pos[c]++;
        end else begin
            case (m_kind[c])
                K_IDLE: begin
                    m_apply(c);
                    if (en) m_seg_phase(c); else m_seg_idle(c);
                end
                K_PHASE: begin
                    if (en) m_seg_period(c); else m_seg_idle(c);
                end
                default: begin
                    m_apply(c);
                    if (en) m_seg_period(c); else m_seg_idle(c);
                end
            endcase
        end
        m_boot[c] = m_boot[c] && !en && (m_kind[c] == K_PHASE);
        if (wr) begin
            s_h[c] = wh; s_l[c] = wl; s_p[c] = wp; m_pend[c] = 1'b1;
        end
    endfunction

    function automatic logic [W-1:0] m_out();
        logic [NC-1:0] c, p, q;
        for (int i = 0; i < NC; i++) begin
            c[i] = (m_kind[i] == K_PERIOD) && (m_seg_h[i] != 0) && (m_pos[i] < m_seg_h[i]);
            p[i] = (m_kind[i] == K_PERIOD) && (m_seg_h[i] != 0) && (m_pos[i] == 0);
            q[i] = m_pend[i];
        end
        return {c, p, q};
    endfunction

    // ---------------- scoreboard ----------------
    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    endfunction

    always @(negedge clock) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("clk_out",      32'(bus.clk_out),      32'(e[3*NC-1:2*NC]));
            check("period_start", 32'(bus.period_start), 32'(e[2*NC-1:NC]));
            check("cfg_pending",  32'(bus.cfg_pending),  32'(e[NC-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        if (!reset) begin
            m_reset();
        end else begin
            for (int c = 0; c < NC; c++)
                m_edge(c, bus.enable[c], bus.sync, bus.cfg_we && (int'(bus.cfg_ch) == c),
                       int'(bus.cfg_high), int'(bus.cfg_low), int'(bus.cfg_phase));
        end
        exp_q.push_back(m_out());
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cfg_write(input int ch, input int h, input int l, input int p);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CHW'(ch);
        bus.cfg_high  = CW'(h);
        bus.cfg_low   = CW'(l);
        bus.cfg_phase = CW'(p);
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic wait_pos(input int c, input kind_e k, input int pos);
        for (int i = 0; i < 40; i++) begin
            if (m_kind[c] == k && m_pos[c] == pos) break;
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2*NC-1:0] want_st;
        bus.enable    = '1;
        bus.sync      = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_high  = '0;
        bus.cfg_low   = '0;
        bus.cfg_phase = '0;
        m_reset();

        // power-up with defaults 3/3/0
        run(3);
        reset = 1'b1;
        run(14);

        // ch1 reprogrammed to 4/2 during its second high cycle
        wait_pos(1, K_PERIOD, 1);
        cfg_write(1, 4, 2, 0);
        run(20);

        // ch2 phase 2, then realign everything
        cfg_write(2, 3, 3, 2);
        run(8);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        run(14);

        // ch0 disabled in its first high cycle, later re-enabled
        wait_pos(0, K_PERIOD, 0);
        bus.enable[0] = 1'b0;
        run(12);
        bus.enable[0] = 1'b1;
        run(12);

        // ch3 degenerate counts
        cfg_write(3, 0, 3, 0);
        run(16);
        cfg_write(3, 5, 0, 0);
        run(20);

        // out-of-range channel writes
        cfg_write(5, 1, 1, 1);
        cfg_write(7, 2, 2, 2);
        run(8);

        // asynchronous reset in the middle of a high pulse
        cfg_write(4, 2, 2, 1);
        wait_pos(0, K_PERIOD, 1);
        reset = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) want_st[2*i +: 2] = ST_PHASE;
        check("async_reset_clk_out",      32'(bus.clk_out),      32'd0);
        check("async_reset_period_start", 32'(bus.period_start), 32'd0);
        check("async_reset_cfg_pending",  32'(bus.cfg_pending),  32'd0);
        check("async_reset_state",        32'(bus.state_dbg),    32'(want_st));
        m_reset();
        exp_q.delete();
        exp_q.push_back(m_out());
        run(2);
        reset = 1'b1;
        run(14);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int k;
            bus.cfg_we    = ($urandom_range(0, 7) == 0);
            bus.cfg_ch    = CHW'($urandom_range(0, 7));
            bus.cfg_high  = CW'($urandom_range(0, 6));
            bus.cfg_low   = CW'($urandom_range(0, 6));
            bus.cfg_phase = CW'($urandom_range(0, 4));
            bus.sync      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) begin
                k = int'($urandom_range(0, NC - 1));
                bus.enable[k] = ~bus.enable[k];
            end
            step();
        end
        bus.cfg_we = 1'b0;
        bus.sync   = 1'b0;
        run(4);

        // ---------------- report ----------------
        @(negedge clock);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
